// File: rtl/fetch_decode_buffer_pkg.sv
// fetch_decode_buffer_pkg: shared front-end widths and the packed queue entry
package fetch_decode_buffer_pkg;
  localparam int INST_WIDTH = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int IF_BATCH_SIZE = 2;
  localparam int BP_GHR_BITS = 8;
  localparam int FDB_DEPTH = 8;
  localparam int FDB_ENTRY_W = INST_WIDTH + 2*INST_ADDR_WIDTH + 1 + BP_GHR_BITS;
  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic pred_taken;
    logic [INST_ADDR_WIDTH-1:0] pred_target;
    logic [BP_GHR_BITS-1:0] pred_hist;
  } fdb_entry_t;
endpackage

// File: rtl/fetch_decode_buffer_ram.sv
// fdb_ram: entry storage with two write ports at tail/tail+1 and two async read ports at head/head+1
module fdb_ram #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we0,
  input  logic [PTR_W-1:0] wa0,
  input  logic [W-1:0] wd0,
  input  logic we1,
  input  logic [PTR_W-1:0] wa1,
  input  logic [W-1:0] wd1,
  input  logic [PTR_W-1:0] ra0,
  output logic [W-1:0] rd0,
  input  logic [PTR_W-1:0] ra1,
  output logic [W-1:0] rd1
);
  logic [W-1:0] mem [DEPTH];
  // storage is never reset; write addresses never collide when both ports fire
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: circular queue compacting 2-wide fetch batches and presenting the two oldest to pre-decode
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = FDB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic [IF_BATCH_SIZE-1:0] in_inst_valid,
  input  logic [INST_WIDTH-1:0] in_inst_0,
  input  logic [INST_WIDTH-1:0] in_inst_1,
  input  logic [INST_ADDR_WIDTH-1:0] in_pc_0,
  input  logic [INST_ADDR_WIDTH-1:0] in_pc_1,
  input  logic in_pred_taken_0,
  input  logic in_pred_taken_1,
  input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_0,
  input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_1,
  input  logic [BP_GHR_BITS-1:0] in_pred_hist_0,
  input  logic [BP_GHR_BITS-1:0] in_pred_hist_1,
  output logic in_ready,
  output logic [IF_BATCH_SIZE-1:0] out_inst_valid,
  output logic [INST_WIDTH-1:0] out_inst_0,
  output logic [INST_WIDTH-1:0] out_inst_1,
  output logic [INST_ADDR_WIDTH-1:0] out_pc_0,
  output logic [INST_ADDR_WIDTH-1:0] out_pc_1,
  output logic out_pred_taken_0,
  output logic out_pred_taken_1,
  output logic [INST_ADDR_WIDTH-1:0] out_pred_target_0,
  output logic [INST_ADDR_WIDTH-1:0] out_pred_target_1,
  output logic [BP_GHR_BITS-1:0] out_pred_hist_0,
  output logic [BP_GHR_BITS-1:0] out_pred_hist_1,
  input  logic out_ready,
  output logic [CNT_W-1:0] count
);
  logic [PTR_W-1:0] head, tail;
  logic accept;
  logic [1:0] n_in, n_out;
  fdb_entry_t in0, in1, wd0, rd0, rd1, s0, s1;
  assign in0 = {in_inst_0, in_pc_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0};
  assign in1 = {in_inst_1, in_pc_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1};
  assign in_ready = count <= CNT_W'(DEPTH - 2);
  // compaction of the fetch batch, head-slot presentation with zeroed invalid slots
  always_comb begin
    accept = in_ready && !flush;
    n_in = {1'b0, in_inst_valid[0]} + {1'b0, in_inst_valid[1]};
    wd0 = in_inst_valid[0] ? in0 : in1;
    out_inst_valid = {count >= CNT_W'(2), count != '0} & {2{!flush}};
    n_out = out_ready ? {1'b0, out_inst_valid[0]} + {1'b0, out_inst_valid[1]} : 2'd0;
    s0 = out_inst_valid[0] ? rd0 : '0;
    s1 = out_inst_valid[1] ? rd1 : '0;
  end
  assign {out_inst_0, out_pc_0, out_pred_taken_0, out_pred_target_0, out_pred_hist_0} = s0;
  assign {out_inst_1, out_pc_1, out_pred_taken_1, out_pred_target_1, out_pred_hist_1} = s1;
  fdb_ram #(.DEPTH(DEPTH), .W(FDB_ENTRY_W), .PTR_W(PTR_W)) u_ram (
    .clk(clk),
    .we0(accept && |in_inst_valid),
    .wa0(tail),
    .wd0(wd0),
    .we1(accept && &in_inst_valid),
    .wa1(tail + PTR_W'(1)),
    .wd1(in1),
    .ra0(head),
    .rd0(rd0),
    .ra1(head + PTR_W'(1)),
    .rd1(rd1)
  );
  // pointer and occupancy update; flush empties the queue ahead of any enqueue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PTR_W'(n_out);
      tail <= tail + (accept ? PTR_W'(n_in) : '0);
      count <= count + (accept ? CNT_W'(n_in) : '0) - CNT_W'(n_out);
    end
  end
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: randomized and directed stimulus checked against a queue model by a negedge monitor
module tb_fetch_decode_buffer;
  import fetch_decode_buffer_pkg::*;
  localparam int DEPTH = FDB_DEPTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic clk, rst_n, flush, in_ready, out_ready;
  logic [1:0] in_inst_valid, out_inst_valid;
  logic [31:0] in_inst_0, in_inst_1, in_pc_0, in_pc_1, in_pred_target_0, in_pred_target_1;
  logic [31:0] out_inst_0, out_inst_1, out_pc_0, out_pc_1, out_pred_target_0, out_pred_target_1;
  logic in_pred_taken_0, in_pred_taken_1, out_pred_taken_0, out_pred_taken_1;
  logic [BP_GHR_BITS-1:0] in_pred_hist_0, in_pred_hist_1, out_pred_hist_0, out_pred_hist_1;
  logic [CNT_W-1:0] count;
  logic [FDB_ENTRY_W-1:0] exp_q[$];
  int pushed_now = 0;
  int errs = 0;
  int checks = 0;

  fetch_decode_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_inst_valid(in_inst_valid),
    .in_inst_0(in_inst_0), .in_inst_1(in_inst_1), .in_pc_0(in_pc_0), .in_pc_1(in_pc_1),
    .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
    .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
    .in_pred_hist_0(in_pred_hist_0), .in_pred_hist_1(in_pred_hist_1),
    .in_ready(in_ready), .out_inst_valid(out_inst_valid),
    .out_inst_0(out_inst_0), .out_inst_1(out_inst_1), .out_pc_0(out_pc_0), .out_pc_1(out_pc_1),
    .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
    .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
    .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_inst_valid = v;
    in_pc_0 = p0;
    in_pc_1 = p1;
    in_inst_0 = $urandom;
    in_inst_1 = $urandom;
    in_pred_taken_0 = 1'($urandom);
    in_pred_taken_1 = 1'($urandom);
    in_pred_target_0 = $urandom;
    in_pred_target_1 = $urandom;
    in_pred_hist_0 = BP_GHR_BITS'($urandom);
    in_pred_hist_1 = BP_GHR_BITS'($urandom);
    out_ready = ordy;
    flush = fl;
    pushed_now = 0;
    if (!fl && exp_q.size() <= DEPTH - 2) begin
      if (v[0]) exp_q.push_back({in_inst_0, in_pc_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0});
      if (v[1]) exp_q.push_back({in_inst_1, in_pc_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1});
      pushed_now = int'(v[0]) + int'(v[1]);
    end
  endtask

  // monitor: DUT-visible entries are the model queue minus this cycle's pushes
  always @(negedge clk) begin
    int c;
    logic [1:0] ev;
    logic [FDB_ENTRY_W-1:0] e0, e1;
    if (rst_n) begin
      c = exp_q.size() - pushed_now;
      ev = {c >= 2 && !flush, c >= 1 && !flush};
      e0 = ev[0] ? exp_q[0] : '0;
      e1 = ev[1] ? exp_q[1] : '0;
      chk("count", 128'(count), 128'(c));
      chk("in_ready", 128'(in_ready), 128'(c <= DEPTH - 2));
      chk("out_valid", 128'(out_inst_valid), 128'(ev));
      chk("slot0", 128'({out_inst_0, out_pc_0, out_pred_taken_0, out_pred_target_0, out_pred_hist_0}), 128'(e0));
      chk("slot1", 128'({out_inst_1, out_pc_1, out_pred_taken_1, out_pred_target_1, out_pred_hist_1}), 128'(e1));
      if (flush) exp_q.delete();
      else if (out_ready) repeat (int'(ev[0]) + int'(ev[1])) void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [31:0] pc;
    rst_n = 0;
    flush = 0;
    out_ready = 0;
    in_inst_valid = 0;
    {in_inst_0, in_inst_1, in_pc_0, in_pc_1, in_pred_target_0, in_pred_target_1} = '0;
    {in_pred_taken_0, in_pred_taken_1, in_pred_hist_0, in_pred_hist_1} = '0;
    #12;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_valid", 128'(out_inst_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_pc0", 128'(out_pc_0), 128'(0));
    @(posedge clk);
    #1 rst_n = 1;
    drive(2'b11, 32'h0, 32'h4, 0, 0);
    in_inst_0 = 32'h00500093;
    in_inst_1 = 32'h00A00113;
    exp_q[0][FDB_ENTRY_W-1 -: 32] = 32'h00500093;
    exp_q[1][FDB_ENTRY_W-1 -: 32] = 32'h00A00113;
    drive(2'b10, 32'hDEAD, 32'h8, 0, 0);
    drive(2'b01, 32'hC, 32'hBEEF, 0, 0);
    drive(2'b00, 0, 0, 1, 0);
    drive(2'b00, 0, 0, 1, 0);
    drive(2'b00, 0, 0, 0, 0);
    pc = 32'h100;
    repeat (3) begin
      drive(2'b11, pc, pc + 4, 0, 0);
      pc += 8;
    end
    drive(2'b01, pc, 0, 0, 0);
    pc += 4;
    drive(2'b11, 32'h900, 32'h904, 0, 0);
    drive(2'b11, 32'h900, 32'h904, 0, 0);
    repeat (5) drive(2'b00, 0, 0, 1, 0);
    pc = 32'h1000;
    repeat (22) begin
      drive(2'b11, pc, pc + 4, 1, 0);
      pc += 8;
    end
    drive(2'b00, 0, 0, 1, 0);
    drive(2'b00, 0, 0, 1, 0);
    drive(2'b11, 32'h2000, 32'h2004, 0, 0);
    drive(2'b11, 32'h2008, 32'h200C, 0, 0);
    drive(2'b01, 32'h2010, 0, 0, 0);
    drive(2'b11, 32'h2014, 32'h2018, 1, 1);
    drive(2'b00, 0, 0, 1, 0);
    repeat (400) drive(2'($urandom), $urandom, $urandom, ($urandom % 4) != 0, ($urandom % 32) == 0);
    drive(2'b00, 0, 0, 0, 1);
    drive(2'b11, 32'h3000, 32'h3004, 0, 0);
    drive(2'b11, 32'h3008, 32'h300C, 0, 0);
    drive(2'b00, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_rst_count", 128'(count), 128'(0));
    chk("async_rst_valid", 128'(out_inst_valid), 128'(0));
    exp_q.delete();
    pushed_now = 0;
    in_inst_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    drive(2'b01, 32'h4000, 0, 0, 0);
    drive(2'b00, 0, 0, 1, 0);
    repeat (3) drive(2'b00, 0, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
